// File: rtl/hazard_stall_controller_pkg.sv
// Shared encodings for the pipeline sequencing controller
// and the EX-stage forwarding logic.
package hazard_stall_controller_pkg;

   localparam logic [1:0] S_RUN     = 2'd0;
   localparam logic [1:0] S_BR_WAIT = 2'd1;
   localparam logic [1:0] S_MULDIV  = 2'd2;
   localparam logic [1:0] S_HALT    = 2'd3;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      ST_RUN     = S_RUN,
      ST_BR_WAIT = S_BR_WAIT,
      ST_MULDIV  = S_MULDIV,
      ST_HALT    = S_HALT
   } state_e;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side bundle: hazard sources in,
// per-stage register controls out.
interface hazard_stall_controller_if;

   logic [4:0] i_id_rs;
   logic [4:0] i_id_rt;
   logic       i_id_uses_rt;
   logic       i_id_is_branch;
   logic       i_id_branch_taken;
   logic [4:0] i_ex_rd;
   logic       i_ex_reg_write;
   logic       i_ex_mem_read;
   logic       i_ex_muldiv;
   logic [4:0] i_mem_rd;
   logic       i_mem_mem_read;
   logic       i_halt;

   logic       o_pc_write;
   logic       o_if_id_write;
   logic       o_if_id_flush;
   logic       o_id_ex_write;
   logic       o_id_ex_bubble;
   logic       o_ex_mem_bubble;
   logic       o_halted;

   modport master (
      output i_id_rs, i_id_rt, i_id_uses_rt,
      output i_id_is_branch, i_id_branch_taken,
      output i_ex_rd, i_ex_reg_write,
      output i_ex_mem_read, i_ex_muldiv,
      output i_mem_rd, i_mem_mem_read, i_halt,
      input  o_pc_write, o_if_id_write,
      input  o_if_id_flush, o_id_ex_write,
      input  o_id_ex_bubble, o_ex_mem_bubble,
      input  o_halted
   );

   modport slave (
      input  i_id_rs, i_id_rt, i_id_uses_rt,
      input  i_id_is_branch, i_id_branch_taken,
      input  i_ex_rd, i_ex_reg_write,
      input  i_ex_mem_read, i_ex_muldiv,
      input  i_mem_rd, i_mem_mem_read, i_halt,
      output o_pc_write, o_if_id_write,
      output o_if_id_flush, o_id_ex_write,
      output o_id_ex_bubble, o_ex_mem_bubble,
      output o_halted
   );

endinterface

// File: rtl/hazard_stall_controller_hazard_detect.sv
// Combinational hazard terms; only dependencies that
// EX forwarding cannot cover in time are flagged.
module hazard_detect
   import hazard_stall_controller_pkg::*;
(
   input  logic [4:0] i_id_rs,
   input  logic [4:0] i_id_rt,
   input  logic       i_id_uses_rt,
   input  logic       i_id_is_branch,
   input  logic [4:0] i_ex_rd,
   input  logic       i_ex_reg_write,
   input  logic       i_ex_mem_read,
   input  logic [4:0] i_mem_rd,
   input  logic       i_mem_mem_read,
   output logic       o_load_use,
   output logic       o_br_ex,
   output logic       o_br_mem_ld
);

   logic ex_nz;
   logic mem_nz;
   logic ex_rs;
   logic ex_rt;
   logic mem_rs;
   logic mem_rt;

   assign ex_nz  = (i_ex_rd != REG_ZERO);
   assign mem_nz = (i_mem_rd != REG_ZERO);
   assign ex_rs  = ex_nz & (i_ex_rd == i_id_rs);
   assign ex_rt  = ex_nz & (i_ex_rd == i_id_rt);
   assign mem_rs = mem_nz & (i_mem_rd == i_id_rs);
   assign mem_rt = mem_nz & (i_mem_rd == i_id_rt);

   assign o_load_use = i_ex_mem_read
                     & (ex_rs | (i_id_uses_rt & ex_rt));

   // Branches compare in ID, so both operands count.
   assign o_br_ex = i_id_is_branch & i_ex_reg_write
                  & (ex_rs | ex_rt);

   assign o_br_mem_ld = i_id_is_branch & i_mem_mem_read
                      & (mem_rs | mem_rt);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing: stall, bubble, flush and halt
// control plus a saturating stall-cycle counter.
module hazard_stall_controller
   import hazard_stall_controller_pkg::*;
#(
   parameter int MULDIV_CYCLES = 4,
   parameter int CNT_W         = 32
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   hazard_stall_controller_if.slave bus,
   output logic [CNT_W-1:0] o_stall_cycles
);

   localparam int MD_W = $clog2(MULDIV_CYCLES);
   localparam logic [MD_W-1:0] MD_INIT =
      MD_W'(MULDIV_CYCLES - 2);

   state_e            state_q, state_d;
   logic [MD_W-1:0]   md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic br_ex;
   logic br_mem_ld;
   logic hazard;

   logic pc_write;
   logic if_id_write;
   logic if_id_flush;
   logic id_ex_write;
   logic id_ex_bubble;
   logic ex_mem_bubble;

   hazard_detect u_hazard_detect (
      .i_id_rs        (bus.i_id_rs),
      .i_id_rt        (bus.i_id_rt),
      .i_id_uses_rt   (bus.i_id_uses_rt),
      .i_id_is_branch (bus.i_id_is_branch),
      .i_ex_rd        (bus.i_ex_rd),
      .i_ex_reg_write (bus.i_ex_reg_write),
      .i_ex_mem_read  (bus.i_ex_mem_read),
      .i_mem_rd       (bus.i_mem_rd),
      .i_mem_mem_read (bus.i_mem_mem_read),
      .o_load_use     (load_use),
      .o_br_ex        (br_ex),
      .o_br_mem_ld    (br_mem_ld)
   );

   assign hazard = load_use | br_ex | br_mem_ld;

   always_comb begin
      state_d       = state_q;
      md_cnt_d      = md_cnt_q;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      if_id_flush   = bus.i_id_branch_taken
                    & bus.i_id_is_branch;
      unique case (state_q)
         ST_RUN: begin
            if (bus.i_ex_muldiv) begin
               pc_write      = 1'b0;
               if_id_write   = 1'b0;
               id_ex_write   = 1'b0;
               ex_mem_bubble = 1'b1;
               if_id_flush   = 1'b0;
               md_cnt_d      = MD_INIT;
               if (MULDIV_CYCLES > 2)
                  state_d = ST_MULDIV;
            end else if (hazard) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
               if_id_flush  = 1'b0;
               // A load result reaches ID compare two cycles out.
               if (br_ex && bus.i_ex_mem_read)
                  state_d = ST_BR_WAIT;
            end else if (bus.i_halt) begin
               if_id_flush = 1'b0;
               state_d     = ST_HALT;
            end
         end
         ST_BR_WAIT: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b0;
            state_d      = ST_RUN;
         end
         ST_MULDIV: begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            if_id_flush   = 1'b0;
            md_cnt_d      = md_cnt_q - MD_W'(1);
            if (md_cnt_q <= MD_W'(1))
               state_d = ST_RUN;
         end
         ST_HALT: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b0;
         end
      endcase
      if (!i_rst_n) begin
         pc_write      = 1'b1;
         if_id_write   = 1'b1;
         id_ex_write   = 1'b1;
         id_ex_bubble  = 1'b0;
         ex_mem_bubble = 1'b0;
         if_id_flush   = 1'b0;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_write && state_q != ST_HALT
          && stall_cnt_q != {CNT_W{1'b1}})
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_RUN;
         md_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         md_cnt_q    <= md_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.o_pc_write      = pc_write;
   assign bus.o_if_id_write   = if_id_write;
   assign bus.o_if_id_flush   = if_id_flush;
   assign bus.o_id_ex_write   = id_ex_write;
   assign bus.o_id_ex_bubble  = id_ex_bubble;
   assign bus.o_ex_mem_bubble = ex_mem_bubble;
   assign bus.o_halted        = (state_q == ST_HALT);
   assign o_stall_cycles      = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller.
module tb_hazard_stall_controller;

   localparam int CNT_W = 4;

   // {pc_w, ifid_w, flush, idex_w, idex_bub, exmem_bub, halted}
   localparam logic [6:0] ADV   = 7'b1101000;
   localparam logic [6:0] FLUSH = 7'b1111000;
   localparam logic [6:0] STALL = 7'b0001100;
   localparam logic [6:0] MD    = 7'b0000010;
   localparam logic [6:0] HALT  = 7'b0001101;

   logic             clk;
   logic             rst_n;
   logic [CNT_W-1:0] stall_cycles;
   logic [6:0]       ctl;
   int               n_cmp;
   int               n_bad;

   hazard_stall_controller_if bus ();

   hazard_stall_controller #(
      .MULDIV_CYCLES (4),
      .CNT_W         (CNT_W)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .bus            (bus),
      .o_stall_cycles (stall_cycles)
   );

   assign ctl = {bus.o_pc_write, bus.o_if_id_write,
                 bus.o_if_id_flush, bus.o_id_ex_write,
                 bus.o_id_ex_bubble, bus.o_ex_mem_bubble,
                 bus.o_halted};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.i_id_rs           = 5'd0;
      bus.i_id_rt           = 5'd0;
      bus.i_id_uses_rt      = 1'b0;
      bus.i_id_is_branch    = 1'b0;
      bus.i_id_branch_taken = 1'b0;
      bus.i_ex_rd           = 5'd0;
      bus.i_ex_reg_write    = 1'b0;
      bus.i_ex_mem_read     = 1'b0;
      bus.i_ex_muldiv       = 1'b0;
      bus.i_mem_rd          = 5'd0;
      bus.i_mem_mem_read    = 1'b0;
      bus.i_halt            = 1'b0;
   endtask

   task automatic set_lu(input logic [4:0] r);
      bus.i_ex_mem_read  = 1'b1;
      bus.i_ex_reg_write = 1'b1;
      bus.i_ex_rd        = r;
      bus.i_id_rs        = r;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      clr();
      // Reset forces advance even with a hazard present
      set_lu(5'd3);
      #2;
      chk("rst_ctl", 32'(ctl), 32'(ADV));
      chk("rst_cnt", 32'(stall_cycles), 0);
      clr();
      #10 rst_n = 1'b1;
      cyc();

      // 1. load-use: single stall
      set_lu(5'd3);
      #1 chk("lu_stall", 32'(ctl), 32'(STALL));
      cyc();
      clr();
      bus.i_mem_mem_read = 1'b1;
      bus.i_mem_rd       = 5'd3;
      bus.i_id_rs        = 5'd4;
      #1 chk("lu_release", 32'(ctl), 32'(ADV));
      chk("lu_cnt", 32'(stall_cycles), 1);
      cyc();
      clr();

      // 2. branch on load in EX: two stalls, then flush
      bus.i_id_is_branch    = 1'b1;
      bus.i_id_branch_taken = 1'b1;
      bus.i_id_rs           = 5'd5;
      bus.i_id_uses_rt      = 1'b1;
      bus.i_ex_mem_read     = 1'b1;
      bus.i_ex_reg_write    = 1'b1;
      bus.i_ex_rd           = 5'd5;
      #1 chk("br_ld_stall1", 32'(ctl), 32'(STALL));
      cyc();
      bus.i_ex_mem_read  = 1'b0;
      bus.i_ex_reg_write = 1'b0;
      bus.i_ex_rd        = 5'd0;
      bus.i_mem_mem_read = 1'b1;
      bus.i_mem_rd       = 5'd5;
      #1 chk("br_ld_stall2", 32'(ctl), 32'(STALL));
      cyc();
      bus.i_mem_mem_read = 1'b0;
      bus.i_mem_rd       = 5'd0;
      #1 chk("br_flush", 32'(ctl), 32'(FLUSH));
      chk("br_cnt", 32'(stall_cycles), 3);
      cyc();
      clr();

      // ALU result for a branch: one stall, no BR_WAIT
      bus.i_id_is_branch = 1'b1;
      bus.i_id_rt        = 5'd8;
      bus.i_ex_reg_write = 1'b1;
      bus.i_ex_rd        = 5'd8;
      #1 chk("br_ex_alu", 32'(ctl), 32'(STALL));
      cyc();
      bus.i_ex_reg_write = 1'b0;
      bus.i_ex_rd        = 5'd0;
      bus.i_mem_rd       = 5'd8;
      #1 chk("br_ex_alu_rel", 32'(ctl), 32'(ADV));
      bus.i_mem_mem_read = 1'b1;
      #1 chk("br_mem_ld", 32'(ctl), 32'(STALL));
      cyc();
      clr();
      #1 chk("br_mem_ld_rel", 32'(ctl), 32'(ADV));
      chk("br_cnt2", 32'(stall_cycles), 5);

      // 4. register 0 and unused rt never stall
      set_lu(5'd0);
      #1 chk("lu_r0", 32'(ctl), 32'(ADV));
      bus.i_ex_rd = 5'd4;
      bus.i_id_rs = 5'd1;
      bus.i_id_rt = 5'd4;
      #1 chk("lu_rt_unused", 32'(ctl), 32'(ADV));
      bus.i_id_uses_rt = 1'b1;
      #1 chk("lu_rt_used", 32'(ctl), 32'(STALL));
      clr();
      cyc();

      // 3. mul/div with a load-use held alongside
      bus.i_ex_muldiv = 1'b1;
      set_lu(5'd9);
      #1 chk("md1", 32'(ctl), 32'(MD));
      cyc();
      bus.i_ex_muldiv = 1'b0;
      #1 chk("md2", 32'(ctl), 32'(MD));
      cyc();
      chk("md3", 32'(ctl), 32'(MD));
      cyc();
      chk("md_then_lu", 32'(ctl), 32'(STALL));
      chk("md_cnt", 32'(stall_cycles), 8);
      clr();
      #1 chk("md_done", 32'(ctl), 32'(ADV));
      cyc();

      // 5. async reset in the middle of MULDIV
      bus.i_ex_muldiv = 1'b1;
      cyc();
      bus.i_ex_muldiv = 1'b0;
      #1 chk("md_pre_rst", 32'(ctl), 32'(MD));
      #2 rst_n = 1'b0;
      #1 chk("rst_async", 32'(ctl), 32'(ADV));
      chk("rst_async_cnt", 32'(stall_cycles), 0);
      #2 rst_n = 1'b1;
      cyc();
      chk("rst_run", 32'(ctl), 32'(ADV));
      set_lu(5'd6);
      #1 chk("rst_lu", 32'(ctl), 32'(STALL));
      cyc();
      clr();
      #1 chk("rst_lu_rel", 32'(ctl), 32'(ADV));
      chk("rst_lu_cnt", 32'(stall_cycles), 1);

      // 6. sticky halt, counter frozen
      bus.i_halt = 1'b1;
      #1 chk("halt_go", 32'(ctl), 32'(ADV));
      cyc();
      bus.i_halt = 1'b0;
      #1 chk("halted", 32'(ctl), 32'(HALT));
      bus.i_id_is_branch    = 1'b1;
      bus.i_id_branch_taken = 1'b1;
      set_lu(5'd2);
      cyc();
      cyc();
      chk("halt_sticky", 32'(ctl), 32'(HALT));
      chk("halt_cnt", 32'(stall_cycles), 1);
      clr();

      // saturation via repeated mul/div
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      cyc();
      for (int i = 0; i < 6; i++) begin
         bus.i_ex_muldiv = 1'b1;
         cyc();
         bus.i_ex_muldiv = 1'b0;
         cyc();
         cyc();
         if (i == 3)
            chk("cnt_pre_sat", 32'(stall_cycles), 12);
         if (i == 4)
            chk("cnt_sat", 32'(stall_cycles), 15);
      end
      chk("cnt_nowrap", 32'(stall_cycles), 15);
      chk("sat_ctl", 32'(ctl), 32'(ADV));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage MIPS core.
- Decides each cycle whether PC, IF/ID, ID/EX and EX/MEM advance, hold, take a bubble or flush.
- Covers load-use hazards, branch-in-ID operand hazards, multi-cycle mul/div occupancy of EX, and a sticky halt.
- Works alongside the EX-stage operand forwarding logic: it stalls only where forwarding cannot resolve the dependency in time.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MULDIV_CYCLES, 4, total cycles a mul/div occupies EX (legal range >=2; adds MULDIV_CYCLES-1 stall cycles)
CNT_W, 32, width of the stall performance counter

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_id_rs  in  5  rs of the instruction in ID
i_id_rt  in  5  rt of the instruction in ID
i_id_uses_rt  in  1  ID instruction reads rt as a source
i_id_is_branch  in  1  ID instruction is BEQ/BNE (compares operands in ID)
i_id_branch_taken  in  1  ID branch comparator result
i_ex_rd  in  5  destination register in EX
i_ex_reg_write  in  1  EX instruction writes a register
i_ex_mem_read  in  1  EX instruction is a load
i_ex_muldiv  in  1  EX instruction is mul/div, first EX cycle
i_mem_rd  in  5  destination register in MEM
i_mem_mem_read  in  1  MEM instruction is a load
i_halt  in  1  HALT decoded in ID
o_pc_write  out  1  PC update enable
o_if_id_write  out  1  IF/ID register enable
o_if_id_flush  out  1  clear IF/ID to NOP
o_id_ex_write  out  1  ID/EX register enable
o_id_ex_bubble  out  1  load NOP control into ID/EX
o_ex_mem_bubble  out  1  load NOP control into EX/MEM
o_halted  out  1  core halted
o_stall_cycles  out  CNT_W  saturating count of cycles with o_pc_write=0 while not halted

Behaviour:
Reset:
- Async clear of state to RUN, mul/div counter to 0, o_stall_cycles to 0, o_halted to 0.
- Outputs during reset: all enables 1, all bubbles and flushes 0.

Hazard terms (combinational, register 0 never matches):
- load_use: i_ex_mem_read, i_ex_rd!=0, and (i_ex_rd==i_id_rs, or (i_id_uses_rt and i_ex_rd==i_id_rt)).
- br_ex: i_id_is_branch, i_ex_reg_write, and i_ex_rd matches rs or rt.
- br_mem_ld: i_id_is_branch, i_mem_mem_read, and i_mem_rd matches rs or rt.

States:
- RUN
  - i_ex_muldiv: go to MULDIV, counter=MULDIV_CYCLES-2. This cycle freezes PC, IF/ID and ID/EX, and bubbles EX/MEM.
  - Otherwise, if load_use, br_ex or br_mem_ld: freeze PC and IF/ID, bubble ID/EX. Stay in RUN, except a branch on a load in EX (br_ex with i_ex_mem_read) goes to BR_WAIT for a second stall cycle.
  - Otherwise, if i_halt: go to HALT.
  - Otherwise: everything advances.
- BR_WAIT
  - One cycle with the same outputs as a RUN stall, then return to RUN.
  - The hazard terms are re-evaluated on return.
- MULDIV
  - Freeze PC, IF/ID and ID/EX; bubble EX/MEM.
  - Decrement the counter; when the counter is 0, return to RUN.
  - Total EX occupancy is exactly MULDIV_CYCLES cycles.
- HALT
  - o_halted=1; PC and IF/ID frozen; ID/EX bubbled.
  - Sticky until reset; o_stall_cycles does not count.

Priority within a cycle: mul/div > stall > halt > flush.

Flush rule:
- o_if_id_flush = i_id_branch_taken & i_id_is_branch, only in cycles where ID advances.
- A branch decided while stalled is ignored; it is re-evaluated when ID advances.

Stall counter:
- Increments when o_pc_write=0 and state != HALT.
- Saturates at all-ones with no wrap.

Reset mid-MULDIV or mid-BR_WAIT aborts to RUN immediately and asynchronously.

Decomposition:
- Shared package: state encoding localparams (RUN, BR_WAIT, MULDIV, HALT) and a REG_ZERO constant. The same zero-register constant is used by the forwarding logic.
- Sub-module: hazard_detect, a pure combinational block producing load_use, br_ex and br_mem_ld.
- FSM, counters and output decode stay in the top module.

Test Plan:
1. LW $3 in EX (i_ex_mem_read=1, i_ex_rd=3) with ADD using rs=3 in ID -> exactly 1 cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; then advance; o_stall_cycles=1.
2. LW $5 in EX with BEQ $5,$0 in ID (i_id_is_branch=1) -> 2 stall cycles via BR_WAIT. On release, branch_taken=1 gives o_if_id_flush=1 for 1 cycle; taken=1 asserted during the stall gives no flush.
3. i_ex_muldiv pulse with MULDIV_CYCLES=4 -> pc_write, id_ex_write=0 and ex_mem_bubble=1 for 3 consecutive cycles, then RUN; stall counter +3. A load_use present at the same time is not bubbled until mul/div finishes.
4. Hazard on register 0 (i_ex_rd=0, load, rs=0) -> no stall. i_id_uses_rt=0 with an rt match -> no stall.
5. i_rst_n pulled low mid-MULDIV, between clock edges -> outputs return to advance state immediately and the counter clears. After release, a normal RUN sequence follows.
6. i_halt=1 -> o_halted=1 next cycle and stays 1 with i_halt deasserted; o_stall_cycles frozen. Preload the counter near all-ones with a long mul/div sequence -> counter saturates and does not wrap.
